jim_bus_master: RTL and testbench

//  Initiator for the BBC 1MHz bus: generates free-running clke and runs paged ("JIM") accesses.

---
 rtl/jim_bus_master.sv | 163 ++++++++++++++++
 tb/tb_jim_bus_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jim_bus_master.sv
// 1MHz bus initiator: free-running clke timebase plus paged (JIM) and raw FCxx accesses.
// Page registers FCFF/FCFE are rewritten only when the cached page no longer matches.
module jim_bus_master #(
  parameter int          CLKE_DIV  = 50,
  parameter int          CLKE_HIGH = 25,
  parameter int          HOLD      = 2,
  parameter logic [4:0]  JIM_ID    = 5'b11001
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic        cmd_fc,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        cache_inv,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        clke,
  output logic        rnw,
  output logic        pgfc_n,
  output logic        pgfd_n,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in
);

  // state  | meaning
  // IDLE   | no command; bus idles at each launch point
  // PG_HI  | write FCFF = {JIM_ID, addr[18:16]}
  // PG_LO  | write FCFE = addr[15:8]
  // ACCESS | FDxx data cycle, or raw FCxx cycle
  typedef enum logic [1:0] {IDLE, PG_HI, PG_LO, ACCESS} state_t;

  localparam int              CW     = $clog2(CLKE_DIV);
  localparam logic [CW-1:0]   LAST   = CW'(CLKE_DIV - 1);
  localparam logic [CW-1:0]   RISE   = CW'(CLKE_DIV - CLKE_HIGH);
  localparam logic [CW-1:0]   LAUNCH = CW'(HOLD);

  state_t      state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic        active;
  logic        c_rnw, c_fc, need_lo;
  logic [18:0] c_addr;
  logic [7:0]  c_wdata;
  logic [2:0]  cache_hi;
  logic [7:0]  cache_lo;
  logic        hi_ok, lo_ok, inv_pend;
  logic        accept, inv_now, miss_hi, miss_lo;

  assign cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign inv_now   = cache_inv || inv_pend;
  assign miss_hi   = inv_now || !hi_ok || (cmd_addr[18:16] != cache_hi);
  assign miss_lo   = inv_now || !lo_ok || (cmd_addr[15:8] != cache_lo);

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      clke         <= 1'b0;
      active       <= 1'b0;
      rnw          <= 1'b1;
      pgfc_n       <= 1'b1;
      pgfd_n       <= 1'b1;
      bus_addr     <= 8'hFF;
      bus_data_out <= 8'h00;
      bus_data_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      c_rnw        <= 1'b1;
      c_fc         <= 1'b0;
      c_addr       <= '0;
      c_wdata      <= 8'h00;
      need_lo      <= 1'b0;
      cache_hi     <= 3'd0;
      cache_lo     <= 8'h00;
      hi_ok        <= 1'b0;
      lo_ok        <= 1'b0;
      inv_pend     <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clke      <= (cnt_nxt >= RISE);
      rsp_valid <= 1'b0;

      // An invalidate seen while busy is deferred so the running sequence's cache updates cannot undo it
      if (cache_inv && !accept) begin
        if (state == IDLE) begin
          hi_ok <= 1'b0;
          lo_ok <= 1'b0;
        end else begin
          inv_pend <= 1'b1;
        end
      end

      if (accept) begin
        c_rnw    <= cmd_rnw;
        c_fc     <= cmd_fc;
        c_addr   <= cmd_addr;
        c_wdata  <= cmd_wdata;
        need_lo  <= miss_lo;
        inv_pend <= 1'b0;
        active   <= 1'b0;
        if (cmd_fc)       state <= ACCESS;
        else if (miss_hi) state <= PG_HI;
        else if (miss_lo) state <= PG_LO;
        else              state <= ACCESS;
      end

      if (cnt == LAUNCH) begin
        active <= (state != IDLE);
        case (state)
          PG_HI: begin
            rnw <= 1'b0; pgfc_n <= 1'b0; pgfd_n <= 1'b1;
            bus_addr <= 8'hFF; bus_data_out <= {JIM_ID, c_addr[18:16]}; bus_data_oe <= 1'b1;
          end
          PG_LO: begin
            rnw <= 1'b0; pgfc_n <= 1'b0; pgfd_n <= 1'b1;
            bus_addr <= 8'hFE; bus_data_out <= c_addr[15:8]; bus_data_oe <= 1'b1;
          end
          ACCESS: begin
            rnw <= c_rnw; pgfc_n <= !c_fc; pgfd_n <= c_fc;
            bus_addr <= c_addr[7:0]; bus_data_out <= c_wdata; bus_data_oe <= !c_rnw;
          end
          default: begin
            rnw <= 1'b1; pgfc_n <= 1'b1; pgfd_n <= 1'b1; bus_data_oe <= 1'b0;
          end
        endcase
      end

      if (cnt == LAST && active) begin
        active <= 1'b0;
        case (state)
          PG_HI: begin
            cache_hi <= c_addr[18:16];
            hi_ok    <= 1'b1;
            state    <= need_lo ? PG_LO : ACCESS;
          end
          PG_LO: begin
            cache_lo <= c_addr[15:8];
            lo_ok    <= 1'b1;
            state    <= ACCESS;
          end
          ACCESS: begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            if (c_rnw) rsp_rdata <= bus_data_in;
            // Software poking the page registers directly leaves the cache stale
            if (c_fc && !c_rnw && (c_addr[7:1] == 7'h7F)) begin
              hi_ok <= 1'b0;
              lo_ok <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jim_bus_master.sv
// Directed bench for jim_bus_master: logs every selected bus cycle at clke rise and checks sequences.
module tb_jim_bus_master;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b1, cmd_fc = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        cache_inv = 1'b0;
  logic        rsp_valid, clke, rnw, pgfc_n, pgfd_n, bus_data_oe;
  logic [7:0]  rsp_rdata, bus_addr, bus_data_out, bus_data_in;

  always #5 clk50 = ~clk50;

  // Responder: read data is a fixed function of the address
  assign bus_data_in = bus_addr ^ 8'h3C;

  jim_bus_master dut (
    .clk50(clk50), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_fc(cmd_fc), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cache_inv(cache_inv), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clke(clke),
    .rnw(rnw), .pgfc_n(pgfc_n), .pgfd_n(pgfd_n), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );

  // {fc_n, fd_n, rnw, oe, addr, data (0 for reads)}, plus clke-rise index
  typedef struct packed {
    logic [19:0] bits;
    logic [15:0] idx;
  } rec_t;

  rec_t       log_q[$];
  logic [7:0] rsp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, rise_cnt = 0, last_rise = 0, meas_period = 0, meas_high = 0;
  logic prev_clke = 1'b0;

  always @(negedge clk50) begin
    rec_t r;
    cyc++;
    if (clke && !prev_clke) begin
      meas_period = cyc - last_rise;
      last_rise   = cyc;
      rise_cnt++;
      if (!pgfc_n || !pgfd_n) begin
        r.bits = {pgfc_n, pgfd_n, rnw, bus_data_oe, bus_addr, bus_data_oe ? bus_data_out : 8'h00};
        r.idx  = 16'(rise_cnt);
        log_q.push_back(r);
      end
    end
    if (!clke && prev_clke) meas_high = cyc - last_rise;
    if (rsp_valid) rsp_q.push_back(rsp_rdata);
    prev_clke = clke;
  end

  task automatic send_cmd(input logic fc, input logic rd, input logic [18:0] addr,
                          input logic [7:0] wd, output bit ok);
    @(negedge clk50);
    cmd_fc = fc; cmd_rnw = rd; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk50);
    end
    @(posedge clk50);
    @(negedge clk50);
    cmd_valid = 1'b0;
    cmd_addr  = 19'h7FFFF;
    cmd_wdata = 8'hEE;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    for (int i = 0; i < 1000 && rsp_q.size() < n; i++) @(negedge clk50);
    repeat (5) @(negedge clk50);
    ok = (rsp_q.size() >= n);
  endtask

  task automatic clear_logs();
    log_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    checks++;
    if ({clke, rnw, pgfc_n, pgfd_n, bus_data_oe, rsp_valid, cmd_ready} !== 7'b0111001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0111001", {clke, rnw, pgfc_n, pgfd_n, bus_data_oe, rsp_valid, cmd_ready});
    end
    checks++;
    if ({bus_addr, bus_data_out, rsp_rdata} !== 24'hFF0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected ff0000", {bus_addr, bus_data_out, rsp_rdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_paged_read();
    logic [19:0] exp_l[$];
    bit ok;
    clear_logs();
    exp_l = '{20'h5FFC9, 20'h5FE23, 20'hA4500};
    send_cmd(1'b0, 1'b1, 19'h12345, 8'h00, ok);
    wait_rsp(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL paged_read_timeout: got no rsp expected rsp"); end
    checks++;
    if (log_q.size() != exp_l.size()) begin
      errors++; $display("FAIL paged_read_count: got %0d expected %0d", log_q.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].bits !== exp_l[i]) begin
        errors++; $display("FAIL paged_read_cyc%0d: got %h expected %h", i, log_q[i].bits, exp_l[i]);
      end
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'h79) begin
      errors++; $display("FAIL paged_read_rsp: got %0d rsp first %h expected 1 rsp 79", rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 8'hXX);
    end
  endtask

  task automatic test_cached_write();
    bit ok;
    clear_logs();
    send_cmd(1'b0, 1'b0, 19'h12346, 8'h5A, ok);
    wait_rsp(1, ok);
    checks++;
    if (log_q.size() != 1 || log_q[0].bits !== 20'h9465A) begin
      errors++; $display("FAIL cached_write: got %0d cycles first %h expected 1 cycle 9465a", log_q.size(), log_q.size() > 0 ? log_q[0].bits : 20'hXXXXX);
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'h79) begin
      errors++; $display("FAIL write_rdata_hold: got %0d rsp first %h expected 1 rsp 79", rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 8'hXX);
    end
  endtask

  task automatic test_page_lo_only();
    logic [19:0] exp_l[$];
    bit ok;
    clear_logs();
    exp_l = '{20'h5FEFF, 20'hA0000};
    send_cmd(1'b0, 1'b1, 19'h1FF00, 8'h00, ok);
    wait_rsp(1, ok);
    checks++;
    if (log_q.size() != exp_l.size()) begin
      errors++; $display("FAIL lo_only_count: got %0d expected %0d", log_q.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].bits !== exp_l[i]) begin
        errors++; $display("FAIL lo_only_cyc%0d: got %h expected %h", i, log_q[i].bits, exp_l[i]);
      end
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'h3C) begin
      errors++; $display("FAIL lo_only_rsp: got %0d rsp expected 1 rsp 3c", rsp_q.size());
    end
  endtask

  task automatic test_raw_fc();
    logic [19:0] exp_l[$];
    bit ok;
    clear_logs();
    exp_l = '{20'h5FFC8, 20'h5FFC9, 20'h5FE23, 20'hA4700, 20'h6A000};
    send_cmd(1'b1, 1'b0, 19'h000FF, 8'hC8, ok);
    wait_rsp(1, ok);
    send_cmd(1'b0, 1'b1, 19'h12347, 8'h00, ok);
    wait_rsp(2, ok);
    send_cmd(1'b1, 1'b1, 19'h000A0, 8'h00, ok);
    wait_rsp(3, ok);
    checks++;
    if (log_q.size() != exp_l.size()) begin
      errors++; $display("FAIL raw_fc_count: got %0d expected %0d", log_q.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].bits !== exp_l[i]) begin
        errors++; $display("FAIL raw_fc_cyc%0d: got %h expected %h", i, log_q[i].bits, exp_l[i]);
      end
    end
    checks++;
    if (rsp_q.size() != 3 || rsp_q[1] !== 8'h7B || rsp_q[2] !== 8'h9C) begin
      errors++; $display("FAIL raw_fc_rsp: got %0d rsp expected 3 rsp (.. 7b 9c)", rsp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] addrs[3] = '{19'h12350, 19'h12351, 19'h12352};
    bit ok;
    clear_logs();
    @(negedge clk50);
    cmd_fc = 1'b0; cmd_rnw = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_addr = addrs[k];
      for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk50);
      @(posedge clk50);
      @(negedge clk50);
    end
    cmd_valid = 1'b0;
    wait_rsp(3, ok);
    checks++;
    if (log_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].bits !== {12'hA50 + 12'(i), 8'h00}) begin
        errors++; $display("FAIL b2b_cyc%0d: got %h expected %h", i, log_q[i].bits, {12'hA50 + 12'(i), 8'h00});
      end
    end
    if (log_q.size() == 3) begin
      checks++;
      if (log_q[2].idx - log_q[0].idx !== 16'd2) begin
        errors++; $display("FAIL b2b_gap: got span %0d expected 2", log_q[2].idx - log_q[0].idx);
      end
    end
    checks++;
    if (rsp_q.size() != 3 || rsp_q[0] !== 8'h6C || rsp_q[1] !== 8'h6D || rsp_q[2] !== 8'h6E) begin
      errors++; $display("FAIL b2b_rsp: got %0d rsp expected 6c 6d 6e", rsp_q.size());
    end
    checks++;
    if (meas_period != 50 || meas_high != 25) begin
      errors++; $display("FAIL clke_shape: got period %0d high %0d expected 50 25", meas_period, meas_high);
    end
  endtask

  task automatic test_cache_inv();
    logic [19:0] exp_l[$];
    bit ok;
    clear_logs();
    exp_l = '{20'h5FFC9, 20'h5FE23, 20'hA4800};
    @(negedge clk50);
    cache_inv = 1'b1;
    @(negedge clk50);
    cache_inv = 1'b0;
    send_cmd(1'b0, 1'b1, 19'h12348, 8'h00, ok);
    wait_rsp(1, ok);
    checks++;
    if (log_q.size() != exp_l.size()) begin
      errors++; $display("FAIL inv_count: got %0d expected %0d", log_q.size(), exp_l.size());
    end
    for (int i = 0; i < exp_l.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].bits !== exp_l[i]) begin
        errors++; $display("FAIL inv_cyc%0d: got %h expected %h", i, log_q[i].bits, exp_l[i]);
      end
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'h74) begin
      errors++; $display("FAIL inv_rsp: got %0d rsp expected 1 rsp 74", rsp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_logs();
    send_cmd(1'b0, 1'b1, 19'h2ABCD, 8'h00, ok);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk50);
      seen = (!pgfc_n && bus_addr == 8'hFE);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_reach_pglo: got no FE cycle expected FE cycle"); end
    repeat (3) @(negedge clk50);
    rst_n = 1'b0;
    @(negedge clk50);
    checks++;
    if ({clke, rnw, pgfc_n, pgfd_n, bus_data_oe, rsp_valid, cmd_ready, bus_addr, bus_data_out} !== 23'b0111001_11111111_00000000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 0111001_11111111_00000000", {clke, rnw, pgfc_n, pgfd_n, bus_data_oe, rsp_valid, cmd_ready, bus_addr, bus_data_out});
    end
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    repeat (300) @(negedge clk50);
    checks++;
    if (rsp_q.size() != 0) begin
      errors++; $display("FAIL mid_no_rsp: got %0d rsp expected 0", rsp_q.size());
    end
    clear_logs();
    send_cmd(1'b0, 1'b1, 19'h12347, 8'h00, ok);
    wait_rsp(1, ok);
    checks++;
    if (log_q.size() != 3 || rsp_q.size() != 1 || rsp_q[0] !== 8'h7B) begin
      errors++; $display("FAIL mid_cache_cleared: got %0d cycles %0d rsp expected 3 cycles 1 rsp 7b", log_q.size(), rsp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_paged_read();
    test_cached_write();
    test_page_lo_only();
    test_raw_fc();
    test_back_to_back();
    test_cache_inv();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
